// File: rtl/scan_mux_pkg.sv
// Shared constants and width helper for the scan_mux channel selector.
package scan_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Index width for n channels; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_mux_dwell.sv
// Dwell counter: raises adv on the cycle a scanned channel has been held long enough.
module scan_mux_dwell #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] dwell,
  output logic             adv
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a dwell lowered below the running count advances at once.
  assign adv = run && (cnt >= dwell);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= adv ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// N-channel data selector with manual select or timed auto-scan, registered outputs.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int W     = 4,
  parameter int N     = 4,
  parameter int DIV_W = 16,
  localparam int SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             dir,
  input  logic             en,
  input  logic [SEL_W-1:0] sel_man,
  input  logic [DIV_W-1:0] dwell,
  input  logic [N*W-1:0]   din,
  output logic [W-1:0]     dout,
  output logic [SEL_W-1:0] sel_out,
  output logic             tick,
  output logic             wrap
);

  logic             scan_run;
  logic             scan_clr;
  logic             adv;
  logic             at_end;
  logic [SEL_W-1:0] sel_next;
  logic [SEL_W-1:0] sel_clamp;

  assign scan_run = (mode == MODE_SCAN) && en;
  assign scan_clr = (mode == MODE_MANUAL);

  scan_mux_dwell #(
    .DIV_W(DIV_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (scan_run),
    .clear (scan_clr),
    .dwell (dwell),
    .adv   (adv)
  );

  // Explicit end-of-range tests keep the index modulo N for any channel count.
  always_comb begin
    sel_clamp = sel_man;
    if (int'(sel_man) > N - 1) begin
      sel_clamp = SEL_W'(N - 1);
    end
    if (dir == DIR_UP) begin
      at_end   = (sel_out == SEL_W'(N - 1));
      sel_next = at_end ? '0 : sel_out + 1'b1;
    end else begin
      at_end   = (sel_out == '0);
      sel_next = at_end ? SEL_W'(N - 1) : sel_out - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_out <= '0;
      dout    <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      dout <= din[int'(sel_out)*W +: W];
      tick <= 1'b0;
      wrap <= 1'b0;
      if (mode == MODE_MANUAL) begin
        sel_out <= sel_clamp;
      end else if (adv) begin
        sel_out <= sel_next;
        tick    <= 1'b1;
        wrap    <= at_end;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed vectors, corner sequences, random vs. model.
module tb_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b1;
  logic        dir = 1'b1;
  logic        en = 1'b1;
  logic [1:0]  sel_man = '0;
  logic [15:0] dwell = '0;
  logic [15:0] din = '0;
  logic [3:0]  dout;
  logic [1:0]  sel_out;
  logic        tick;
  logic        wrap;

  logic        mode3 = 1'b0;
  logic [1:0]  sel_man3 = '0;
  logic [3:0]  dout3;
  logic [1:0]  sel_out3;
  logic        tick3;
  logic        wrap3;

  int pass_cnt = 0;
  int total_cnt = 0;

  int m_sel = 0, m_cnt = 0, m_dout = 0, m_tick = 0, m_wrap = 0;

  always #5 clk = ~clk;

  scan_mux #(.W(4), .N(4), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .dir(dir), .en(en),
    .sel_man(sel_man), .dwell(dwell), .din(din),
    .dout(dout), .sel_out(sel_out), .tick(tick), .wrap(wrap)
  );

  scan_mux #(.W(4), .N(3), .DIV_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .dir(dir), .en(en),
    .sel_man(sel_man3), .dwell(dwell), .din(din[11:0]),
    .dout(dout3), .sel_out(sel_out3), .tick(tick3), .wrap(wrap3)
  );

  typedef struct {
    logic        rst_n, mode, dir, en;
    logic [1:0]  sel_man;
    logic [15:0] dwell, din;
    int          esel, edout, etick, ewrap;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic m, logic d, logic e, logic [1:0] sm,
                              logic [15:0] dw, logic [15:0] di,
                              int es, int ed, int et, int ew);
    vec_t v;
    v.rst_n = r; v.mode = m; v.dir = d; v.en = e; v.sel_man = sm;
    v.dwell = dw; v.din = di;
    v.esel = es; v.edout = ed; v.etick = et; v.ewrap = ew;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: channel held dwell+1 enabled cycles, index stepped modulo N.
  task automatic model_edge();
    int nsel;
    if (!rst_n) begin
      m_sel = 0; m_cnt = 0; m_dout = 0; m_tick = 0; m_wrap = 0;
    end else begin
      m_dout = int'((din >> (4 * m_sel)) & 16'hF);
      m_tick = 0;
      m_wrap = 0;
      if (mode == 1'b0) begin
        m_sel = (int'(sel_man) > 3) ? 3 : int'(sel_man);
        m_cnt = 0;
      end else if (en) begin
        if (m_cnt >= int'(dwell)) begin
          nsel   = dir ? (m_sel + 1) % 4 : (m_sel + 3) % 4;
          m_wrap = dir ? int'(nsel == 0) : int'(nsel == 3);
          m_sel  = nsel;
          m_cnt  = 0;
          m_tick = 1;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, "_sel"},  int'(sel_out), m_sel);
    chk({tag, "_dout"}, int'(dout),    m_dout);
    chk({tag, "_tick"}, int'(tick),    m_tick);
    chk({tag, "_wrap"}, int'(wrap),    m_wrap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic got_tick;

    // Reset, scan up with dwell 2, scan down with dwell 0, manual select.
    tbl.push_back(mk(0, 1, 1, 1, 0, 2, 16'hABCD, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 2, 16'hABCD, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 0, 4'hD, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 0, 4'hD, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 1, 4'hD, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 1, 4'hC, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 1, 4'hC, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 2, 4'hC, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 2, 4'hB, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 2, 4'hB, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 3, 4'hB, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 3, 4'hA, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 3, 4'hA, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 0, 4'hA, 1, 1));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 16'hABCD, 0, 4'hD, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'hABCD, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hABCD, 3, 4'hD, 1, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hABCD, 2, 4'hA, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hABCD, 1, 4'hB, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hABCD, 0, 4'hC, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hABCD, 3, 4'hD, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 2, 0, 16'h4321, 2, 4'h4, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 16'h4321, 2, 4'h3, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; mode = tbl[i].mode; dir = tbl[i].dir; en = tbl[i].en;
      sel_man = tbl[i].sel_man; dwell = tbl[i].dwell; din = tbl[i].din;
      step();
      chk($sformatf("vec%0d_sel", i),  int'(sel_out), tbl[i].esel);
      chk($sformatf("vec%0d_dout", i), int'(dout),    tbl[i].edout);
      chk($sformatf("vec%0d_tick", i), int'(tick),    tbl[i].etick);
      chk($sformatf("vec%0d_wrap", i), int'(wrap),    tbl[i].ewrap);
    end

    // N=3: out-of-range manual select clamps, then scan down wraps 0 -> 2.
    mode3 = 1'b0; sel_man3 = 2'd3;
    step();
    chk("n3_clamp", int'(sel_out3), 2);
    mode3 = 1'b1; dir = 1'b0; dwell = 16'd0; en = 1'b1;
    step(); chk("n3_down1", int'(sel_out3), 1);
    step(); chk("n3_down0", int'(sel_out3), 0); chk("n3_nowrap", int'(wrap3), 0);
    step(); chk("n3_wrap_sel", int'(sel_out3), 2); chk("n3_wrap", int'(wrap3), 1);
    mode3 = 1'b0;

    // Freeze mid-dwell: en low for 4 cycles at count 3, dwell 5.
    mode = 1'b1; dir = 1'b1; dwell = 16'd5; en = 1'b1; din = 16'h9876;
    do_reset();
    for (int i = 0; i < 20 && m_cnt != 3; i++) begin
      step(); check_model("frz_pre");
    end
    chk("frz_reached_cnt3", m_cnt, 3);
    n = m_sel;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("frz_sel_hold", int'(sel_out), n);
      chk("frz_tick0", int'(tick), 0);
      chk("frz_wrap0", int'(wrap), 0);
      chk("frz_dout", int'(dout), m_dout);
    end
    en = 1'b1;
    n = 0;
    got_tick = 1'b0;
    for (int i = 0; i < 10 && !got_tick; i++) begin
      step(); n++;
      got_tick = tick;
    end
    chk("frz_resume_edges", n, 3);

    // Reset mid-dwell at channel 2, count 1, then scanning resumes.
    dwell = 16'd3; din = 16'h5A3C;
    do_reset();
    for (int i = 0; i < 40 && !(m_sel == 2 && m_cnt == 1); i++) begin
      step(); check_model("mrst_pre");
    end
    chk("mrst_reached", int'(m_sel == 2 && m_cnt == 1), 1);
    rst_n = 1'b0;
    step();
    chk("mrst_sel", int'(sel_out), 0);
    chk("mrst_dout", int'(dout), 0);
    chk("mrst_tick", int'(tick), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(); check_model("mrst_post");
    end

    // Randomised run against the reference model.
    for (int i = 0; i < 1500; i++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      mode    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      en      = ($urandom_range(0, 3) != 0);
      sel_man = 2'($urandom);
      if ($urandom_range(0, 15) == 0) dwell = 16'($urandom_range(0, 4));
      din     = 16'($urandom);
      step();
      check_model("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
